gmii_rx_frame_ctrl: RTL

Receive-side frame controller behind the RGMII-to-GMII converter, in the gmii_rx_clk domain.
- Locates preamble/SFD and strips them.
- Filters on destination MAC.
- Forwards accepted frames (DA through FCS) as a byte stream with start/end markers.
- Reports per-frame length and error status, and counts dropped frames.
- Feeds the upstream MAC/IP receive logic.

---
 rtl/gmii_rx_pkg.sv | 24 ++
 rtl/gmii_rx_frame_ctrl_crc32_d8.sv | 36 +++
 rtl/gmii_rx_frame_ctrl.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/gmii_rx_pkg.sv
// Shared constants, state encoding and error-bit positions
// for the GMII receive frame controller.
package gmii_rx_pkg;

   localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0]  SFD_BYTE      = 8'hD5;
   localparam logic [47:0] BCAST_MAC     = 48'hFFFF_FFFF_FFFF;
   localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;
   localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;

   localparam int ERR_GMII = 0;
   localparam int ERR_RSVD = 1;
   localparam int ERR_LEN  = 2;
   localparam int ERR_CRC  = 3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PREAMBLE,
      ST_DATA,
      ST_DRAIN,
      ST_DROP
   } rx_state_e;

endpackage

// File: rtl/gmii_rx_frame_ctrl_crc32_d8.sv
// Byte-wide CRC-32 update, data bits consumed LSB first,
// register kept MSB-first so the good-frame residue is C704DD7B.
module crc32_d8
   import gmii_rx_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_clr,
   input  logic        i_en,
   input  logic [7:0]  i_data,
   output logic [31:0] o_crc
);

   logic [31:0] r_crc;
   logic [31:0] w_nxt;

   always_comb begin
      w_nxt = r_crc;
      for (int i = 0; i < 8; i++) begin
         if (w_nxt[31] ^ i_data[i])
            w_nxt = {w_nxt[30:0], 1'b0} ^ CRC_POLY;
         else
            w_nxt = {w_nxt[30:0], 1'b0};
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr)
         r_crc <= '1;
      else if (i_en)
         r_crc <= w_nxt;
   end

   assign o_crc = r_crc;

endmodule

// File: rtl/gmii_rx_frame_ctrl.sv
// GMII receive frame controller: preamble strip, DA filter, 7-cycle
// forward pipe, status. Define RX_CRC_CHECK_EN to add FCS checking.
module gmii_rx_frame_ctrl
   import gmii_rx_pkg::*;
#(
   parameter logic [47:0] LOCAL_MAC     = 48'h000A3501FEC0,
   parameter bit          ACCEPT_BCAST  = 1'b1,
   parameter int          MIN_FRAME_LEN = 64,
   parameter int          MAX_FRAME_LEN = 1518
) (
   input  logic        gmii_rx_clk,
   input  logic        reset,
   input  logic [7:0]  gmii_rxd,
   input  logic        gmii_rx_dv,
   input  logic        gmii_rx_er,
   input  logic        rx_en,
   output logic [7:0]  out_data,
   output logic        out_valid,
   output logic        out_sof,
   output logic        out_eof,
   output logic        frame_done,
   output logic        frame_ok,
   output logic [10:0] frame_len,
   output logic [3:0]  err_flags,
   output logic [15:0] drop_cnt
);

   localparam int          DLY   = 7;
   localparam logic [10:0] MIN_L = 11'(MIN_FRAME_LEN);
   localparam logic [10:0] MAX_L = 11'(MAX_FRAME_LEN);

   rx_state_e      r_state;
   rx_state_e      w_state_nxt;
   logic           r_dv_q;
   logic [7:0]     r_dly [DLY];
   logic [DLY-1:0] r_vld;
   logic [DLY-1:0] r_sof;
   logic [DLY-1:0] r_last;
   logic [10:0]    r_cnt;
   logic           r_er;
   logic [47:0]    w_da;
   logic           w_da_hit;
   logic           w_take;
   logic           w_kill;
   logic           w_drop_inc;
   logic           w_eof_mark;
   logic           w_clr_frame;
   logic           w_crc_bad;
   logic [3:0]     w_err;

   assign w_da = {r_dly[4], r_dly[3], r_dly[2],
                  r_dly[1], r_dly[0], gmii_rxd};
   assign w_da_hit = (w_da == LOCAL_MAC) ||
                     (ACCEPT_BCAST && (w_da == BCAST_MAC));

`ifdef RX_CRC_CHECK_EN
   logic [31:0] w_crc;

   crc32_d8 u_crc (
      .i_clk  (gmii_rx_clk),
      .i_rst  (reset),
      .i_clr  (w_clr_frame),
      .i_en   (w_take),
      .i_data (gmii_rxd),
      .o_crc  (w_crc)
   );

   assign w_crc_bad = (w_crc != CRC_RESIDUE);
`else
   assign w_crc_bad = 1'b0;
`endif

   always_comb begin
      w_err           = '0;
      w_err[ERR_GMII] = r_er;
      w_err[ERR_LEN]  = (r_cnt < MIN_L) || (r_cnt > MAX_L);
      w_err[ERR_CRC]  = w_crc_bad;
   end

   always_ff @(posedge gmii_rx_clk) begin
      if (reset)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_take      = 1'b0;
      w_kill      = 1'b0;
      w_drop_inc  = 1'b0;
      w_eof_mark  = 1'b0;
      w_clr_frame = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (gmii_rx_dv && !r_dv_q && gmii_rxd == PREAMBLE_BYTE)
               w_state_nxt = ST_PREAMBLE;
         end
         ST_PREAMBLE: begin
            if (!gmii_rx_dv) begin
               w_state_nxt = ST_IDLE;
            end else if (gmii_rxd == SFD_BYTE) begin
               if (rx_en) begin
                  w_state_nxt = ST_DATA;
                  w_clr_frame = 1'b1;
               end else begin
                  w_state_nxt = ST_DROP;
                  w_drop_inc  = 1'b1;
               end
            end else if (gmii_rxd != PREAMBLE_BYTE) begin
               w_state_nxt = ST_DROP;
            end
         end
         ST_DATA: begin
            if (gmii_rx_dv) begin
               w_take = 1'b1;
               if (r_cnt == 11'd5 && !w_da_hit) begin
                  w_state_nxt = ST_DROP;
                  w_drop_inc  = 1'b1;
                  w_kill      = 1'b1;
               end
            end else if (r_cnt < 11'd6) begin
               w_state_nxt = ST_IDLE;
               w_drop_inc  = 1'b1;
               w_kill      = 1'b1;
            end else begin
               w_state_nxt = ST_DRAIN;
               w_eof_mark  = 1'b1;
            end
         end
         ST_DRAIN: begin
            if (r_last[DLY-1])
               w_state_nxt = ST_IDLE;
         end
         ST_DROP: begin
            if (!gmii_rx_dv)
               w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // dv_q keeps tracking through reset so a frame tail never looks like a new start
   always_ff @(posedge gmii_rx_clk) begin
      r_dv_q <= gmii_rx_dv;
      if (reset) begin
         for (int i = 0; i < DLY; i++)
            r_dly[i] <= '0;
         r_vld      <= '0;
         r_sof      <= '0;
         r_last     <= '0;
         r_cnt      <= '0;
         r_er       <= 1'b0;
         out_data   <= '0;
         out_valid  <= 1'b0;
         out_sof    <= 1'b0;
         out_eof    <= 1'b0;
         frame_done <= 1'b0;
         frame_ok   <= 1'b0;
         frame_len  <= '0;
         err_flags  <= '0;
         drop_cnt   <= '0;
      end else begin
         r_dly[0] <= gmii_rxd;
         for (int i = 1; i < DLY; i++)
            r_dly[i] <= r_dly[i-1];
         r_vld  <= w_kill ? '0 : {r_vld[DLY-2:0], w_take};
         r_sof  <= w_kill ? '0 :
                   {r_sof[DLY-2:0], w_take && (r_cnt == 11'd0)};
         r_last <= {r_last[DLY-2:1], w_eof_mark, 1'b0};
         if (w_clr_frame) begin
            r_cnt <= '0;
            r_er  <= 1'b0;
         end else if (w_take) begin
            if (r_cnt != 11'h7FF)
               r_cnt <= r_cnt + 11'd1;
            if (gmii_rx_er)
               r_er <= 1'b1;
         end
         out_data   <= r_dly[DLY-1];
         out_valid  <= r_vld[DLY-1];
         out_sof    <= r_sof[DLY-1];
         out_eof    <= r_last[DLY-1];
         frame_done <= r_last[DLY-1];
         if (r_last[DLY-1]) begin
            frame_len <= r_cnt;
            err_flags <= w_err;
            frame_ok  <= (w_err == 4'd0);
         end
         if (w_drop_inc)
            drop_cnt <= drop_cnt + 16'd1;
      end
   end

endmodule
